// File: rtl/reel_positioner.sv
// rtl/reel_positioner.sv - closed-count reel position controller driving the stepper direction command
module reel_positioner #(
    parameter int POS_W        = 12,
    parameter int MAX_POS      = 4000,
    parameter int STEP_DIV     = 512,
    parameter int SETTLE_TICKS = 4,
    parameter int HOME_TIMEOUT = 4200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_target,
    input  logic             stop,
    input  logic             home_sw,
    output logic [1:0]       dir,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SET_W  = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;
    localparam int HOME_W = (HOME_TIMEOUT > 1) ? $clog2(HOME_TIMEOUT + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(STEP_DIV - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_TICKS - 1);
    localparam logic [HOME_W-1:0] HOME_LAST   = HOME_W'(HOME_TIMEOUT - 1);
    localparam logic [POS_W-1:0]  MAX_V       = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0]  POS_ONE     = POS_W'(1);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_IN   = 2'b10;
    localparam logic [1:0] DIR_OUT  = 2'b11;

    typedef enum logic [2:0] {
        S_HOME,
        S_IDLE,
        S_OUT,
        S_IN,
        S_SETTLE,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [HOME_W-1:0] home_q, home_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  tgt_q, tgt_d;
    logic [1:0]        dir_q, dir_d;
    logic              done_q, done_d;
    logic              tick;
    logic [POS_W-1:0]  tgt_clamp;
    logic [POS_W-1:0]  pos_inc;
    logic [POS_W-1:0]  pos_dec;

    assign tick      = (div_q == DIV_LAST);
    assign div_d     = tick ? '0 : div_q + DIV_W'(1);
    assign tgt_clamp = (cmd_target > MAX_V) ? MAX_V : cmd_target;
    assign pos_inc   = pos_q + POS_ONE;
    assign pos_dec   = pos_q - POS_ONE;

    // Command acceptance is blocked during the done pulse so done and acceptance never coincide.
    assign cmd_ready = (state_q == S_IDLE) && !done_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault     = (state_q == S_FAULT);
    assign done      = done_q;
    assign dir       = dir_q;
    assign position  = pos_q;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        tgt_d    = tgt_q;
        settle_d = '0;
        home_d   = '0;
        done_d   = 1'b0;
        case (state_q)
            S_HOME: begin
                home_d = home_q;
                if (tick) begin
                    if (home_sw) begin
                        pos_d   = '0;
                        state_d = S_SETTLE;
                    end else if (home_q == HOME_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        home_d = home_q + HOME_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    tgt_d = tgt_clamp;
                    if (tgt_clamp > pos_q) begin
                        state_d = S_OUT;
                    end else if (tgt_clamp < pos_q) begin
                        state_d = S_IN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (tick) begin
                    pos_d = pos_inc;
                    if (pos_inc == tgt_q) begin
                        state_d = S_SETTLE;
                    end
                end
                if (stop) begin
                    state_d = S_SETTLE;
                end
            end
            S_IN: begin
                // The home switch wins over the target: the reel is physically fully in.
                if (tick) begin
                    if (home_sw) begin
                        pos_d   = '0;
                        state_d = S_SETTLE;
                    end else if (pos_q == '0) begin
                        state_d = S_SETTLE;
                    end else begin
                        pos_d = pos_dec;
                        if (pos_dec == tgt_q) begin
                            state_d = S_SETTLE;
                        end
                    end
                end
                if (stop) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q;
                if (tick) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Direction is registered from the next state, so it only moves with state transitions.
    always_comb begin
        dir_d = DIR_STOP;
        case (state_d)
            S_HOME:  dir_d = DIR_IN;
            S_IN:    dir_d = DIR_IN;
            S_OUT:   dir_d = DIR_OUT;
            default: dir_d = DIR_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_HOME;
            div_q    <= '0;
            settle_q <= '0;
            home_q   <= '0;
            pos_q    <= '0;
            tgt_q    <= '0;
            dir_q    <= DIR_STOP;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            settle_q <= settle_d;
            home_q   <= home_d;
            pos_q    <= pos_d;
            tgt_q    <= tgt_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_reel_positioner.sv
// tb/tb_reel_positioner.sv - directed self-checking bench for reel_positioner
module tb_reel_positioner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [13:0] cmd_target = '0;
    logic        stop = 1'b0;
    logic        home_sw = 1'b0;
    logic [1:0]  dir;
    logic [13:0] position;
    logic        busy;
    logic        done;
    logic        fault;

    int passed = 0;
    int total = 0;
    int cyc = 0;

    reel_positioner #(
        .POS_W(14),
        .MAX_POS(4000),
        .STEP_DIV(4),
        .SETTLE_TICKS(2),
        .HOME_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_target(cmd_target),
        .stop(stop),
        .home_sw(home_sw),
        .dir(dir),
        .position(position),
        .busy(busy),
        .done(done),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // Ticks land on posedges where cyc becomes a multiple of 4 (divider restarts at reset).
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic wait_tick();
        @(negedge clk);
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    task automatic issue(input logic [13:0] t);
        cmd_target = t;
        cmd_valid  = 1'b1;
        cycle();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        total++; if (dir !== 2'b00) $display("FAIL reset_dir: got %b want 00", dir); else passed++;
        total++; if (position !== 14'd0) $display("FAIL reset_pos: got %0d want 0", position); else passed++;
        total++; if ({busy, cmd_ready, done, fault} !== 4'b1000) $display("FAIL reset_flags: got %b want 1000", {busy, cmd_ready, done, fault}); else passed++;
        reset = 1'b0;
        cycle();
        total++; if (dir !== 2'b10) $display("FAIL home_dir: got %b want 10", dir); else passed++;
        wait_tick();
        wait_tick();
        total++; if (dir !== 2'b10) $display("FAIL home_dir_t2: got %b want 10", dir); else passed++;
        home_sw = 1'b1;
        wait_tick();
        home_sw = 1'b0;
        total++; if (dir !== 2'b00) $display("FAIL homed_dir: got %b want 00", dir); else passed++;
        total++; if (position !== 14'd0) $display("FAIL homed_pos: got %0d want 0", position); else passed++;
        wait_tick();
        total++; if (done !== 1'b0) $display("FAIL home_settle1_done: got %b want 0", done); else passed++;
        wait_tick();
        total++; if ({done, cmd_ready, busy} !== 3'b100) $display("FAIL home_done: got %b want 100", {done, cmd_ready, busy}); else passed++;
        cycle();
        total++; if ({done, cmd_ready, busy} !== 3'b010) $display("FAIL home_idle: got %b want 010", {done, cmd_ready, busy}); else passed++;
    endtask

    task automatic test_move_out_in();
        issue(14'd5);
        total++; if ({dir, cmd_ready, busy} !== 4'b1101) $display("FAIL out_start: got %b want 1101", {dir, cmd_ready, busy}); else passed++;
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            total++; if (position !== 14'(k)) $display("FAIL out_pos%0d: got %0d want %0d", k, position, k); else passed++;
            total++; if (dir !== ((k < 5) ? 2'b11 : 2'b00)) $display("FAIL out_dir%0d: got %b", k, dir); else passed++;
        end
        wait_tick();
        total++; if (done !== 1'b0) $display("FAIL out_settle1: got %b want 0", done); else passed++;
        wait_tick();
        total++; if (done !== 1'b1) $display("FAIL out_done: got %b want 1", done); else passed++;
        cycle();
        issue(14'd2);
        total++; if (dir !== 2'b10) $display("FAIL in_start: got %b want 10", dir); else passed++;
        wait_tick();
        total++; if (position !== 14'd4) $display("FAIL in_pos1: got %0d want 4", position); else passed++;
        wait_tick();
        wait_tick();
        total++; if ({position, dir} !== {14'd2, 2'b00}) $display("FAIL in_end: got pos %0d dir %b want 2 00", position, dir); else passed++;
        wait_tick();
        wait_tick();
        total++; if (done !== 1'b1) $display("FAIL in_done: got %b want 1", done); else passed++;
        cycle();
    endtask

    task automatic test_same_target();
        cmd_target = 14'd2;
        cmd_valid  = 1'b1;
        cycle();
        total++; if ({done, cmd_ready, busy, dir} !== 5'b10000) $display("FAIL same_done: got %b want 10000", {done, cmd_ready, busy, dir}); else passed++;
        cycle();
        cmd_valid = 1'b0;
        total++; if ({done, cmd_ready} !== 2'b01) $display("FAIL no_accept_on_done: got %b want 01", {done, cmd_ready}); else passed++;
        cycle();
    endtask

    task automatic test_clamp();
        issue(14'd9000);
        total++; if (dir !== 2'b11) $display("FAIL clamp_dir: got %b want 11", dir); else passed++;
        repeat (3997) wait_tick();
        total++; if ({position, dir} !== {14'd3999, 2'b11}) $display("FAIL clamp_near: got pos %0d dir %b want 3999 11", position, dir); else passed++;
        wait_tick();
        total++; if ({position, dir} !== {14'd4000, 2'b00}) $display("FAIL clamp_end: got pos %0d dir %b want 4000 00", position, dir); else passed++;
        wait_tick();
        wait_tick();
        total++; if ({done, position} !== {1'b1, 14'd4000}) $display("FAIL clamp_done: got done %b pos %0d want 1 4000", done, position); else passed++;
        cycle();
    endtask

    task automatic test_early_home_from_max();
        issue(14'd0);
        total++; if (dir !== 2'b10) $display("FAIL max_in_dir: got %b want 10", dir); else passed++;
        wait_tick();
        total++; if (position !== 14'd3999) $display("FAIL max_in_pos: got %0d want 3999", position); else passed++;
        home_sw = 1'b1;
        wait_tick();
        home_sw = 1'b0;
        total++; if ({position, dir, busy} !== {14'd0, 2'b00, 1'b1}) $display("FAIL max_in_home: got pos %0d dir %b busy %b", position, dir, busy); else passed++;
        wait_tick();
        wait_tick();
        total++; if (done !== 1'b1) $display("FAIL max_in_done: got %b want 1", done); else passed++;
        cycle();
    endtask

    task automatic test_stop();
        issue(14'd10);
        repeat (4) wait_tick();
        total++; if ({position, dir} !== {14'd4, 2'b11}) $display("FAIL stop_pre: got pos %0d dir %b want 4 11", position, dir); else passed++;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        total++; if ({position, dir, busy} !== {14'd4, 2'b00, 1'b1}) $display("FAIL stop_hold: got pos %0d dir %b busy %b", position, dir, busy); else passed++;
        wait_tick();
        total++; if ({position, done} !== {14'd4, 1'b0}) $display("FAIL stop_settle1: got pos %0d done %b", position, done); else passed++;
        wait_tick();
        total++; if ({position, done} !== {14'd4, 1'b1}) $display("FAIL stop_done: got pos %0d done %b", position, done); else passed++;
        cycle();
    endtask

    task automatic test_stop_on_tick();
        issue(14'd8);
        wait_tick();
        total++; if (position !== 14'd5) $display("FAIL stoptick_pre: got %0d want 5", position); else passed++;
        repeat (3) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        total++; if ({position, dir} !== {14'd6, 2'b00}) $display("FAIL stoptick: got pos %0d dir %b want 6 00", position, dir); else passed++;
        wait_tick();
        wait_tick();
        total++; if (done !== 1'b1) $display("FAIL stoptick_done: got %b want 1", done); else passed++;
        cycle();
    endtask

    task automatic test_early_home();
        issue(14'd3);
        total++; if (dir !== 2'b10) $display("FAIL early_dir: got %b want 10", dir); else passed++;
        wait_tick();
        total++; if (position !== 14'd5) $display("FAIL early_pos1: got %0d want 5", position); else passed++;
        home_sw = 1'b1;
        wait_tick();
        home_sw = 1'b0;
        total++; if ({position, dir} !== {14'd0, 2'b00}) $display("FAIL early_home: got pos %0d dir %b want 0 00", position, dir); else passed++;
        wait_tick();
        wait_tick();
        total++; if (done !== 1'b1) $display("FAIL early_done: got %b want 1", done); else passed++;
        cycle();
        total++; if ({cmd_ready, busy, position} !== {2'b10, 14'd0}) $display("FAIL early_idle: got ready %b busy %b pos %0d", cmd_ready, busy, position); else passed++;
    endtask

    task automatic test_home_timeout();
        home_sw = 1'b0;
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (7) wait_tick();
        total++; if ({fault, dir} !== 3'b010) $display("FAIL timeout_pre: got fault %b dir %b want 0 10", fault, dir); else passed++;
        wait_tick();
        total++; if ({fault, dir, cmd_ready, busy} !== 5'b10000) $display("FAIL timeout: got %b want 10000", {fault, dir, cmd_ready, busy}); else passed++;
        cmd_target = 14'd5;
        cmd_valid  = 1'b1;
        repeat (3) wait_tick();
        cmd_valid  = 1'b0;
        total++; if ({fault, dir, position} !== {3'b100, 14'd0}) $display("FAIL fault_sticky: got fault %b dir %b pos %0d", fault, dir, position); else passed++;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        total++; if ({fault, dir, busy} !== 4'b0001) $display("FAIL fault_reset: got %b want 0001", {fault, dir, busy}); else passed++;
        cycle();
        total++; if (dir !== 2'b10) $display("FAIL rehome_dir: got %b want 10", dir); else passed++;
    endtask

    initial begin
        test_reset();
        test_move_out_in();
        test_same_target();
        test_clamp();
        test_early_home_from_max();
        test_stop();
        test_stop_on_tick();
        test_early_home();
        test_home_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
